// File: rtl/spi_regbus_slave.sv
`timescale 1ns/1ps
// spi_regbus_slave: mode-0 SPI slave bridging 40-bit frames {rw, addr[6:0], data[31:0]} to a register bus.
// Optional macro SPI_MISO_TRISTATE_EN floats SPI_MISO while deselected or in reset.
module spi_regbus_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        SPI_CSL,
   input  logic        SPI_SCLK,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic        we,
   output logic        re,
   output logic [6:0]  addr,
   output logic [31:0] wdat,
   input  logic [31:0] rdat
);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] csl_sync, sclk_sync, mosi_sync, vld_pipe;
   logic        csl_s, sclk_s, mosi_s, csl_d, sclk_d, armed;
   logic        csl_fall, sclk_rise, bit_ok;
   logic [5:0]  cnt;
   logic [31:0] in_sr, miso_sr;
   logic        rw, rd_pend, miso_bit;

   // armed stays low until CSL has been seen high through a flushed synchronizer,
   // so releasing reset mid-frame cannot fake a CSL falling edge
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         csl_sync  <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         vld_pipe  <= '0;
         csl_d     <= 1'b1;
         sclk_d    <= 1'b0;
         armed     <= 1'b0;
      end else begin
         csl_sync  <= {csl_sync[SYNC_STAGES-2:0], SPI_CSL};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
         csl_d     <= csl_s;
         sclk_d    <= sclk_s;
         if (vld_pipe[SYNC_STAGES-1] && csl_s) armed <= 1'b1;
      end

   assign csl_s     = csl_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign csl_fall  = armed & csl_d & ~csl_s;
   assign sclk_rise = sclk_s & ~sclk_d;
   // CSL high wins over a coincident SCLK edge: the edge is dropped and the frame aborts
   assign bit_ok    = sclk_rise & ~csl_s & ((state == HDR) || (state == DATA));

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (csl_fall) state_nxt = HDR;
         HDR:  if (csl_s) state_nxt = IDLE;
               else if (sclk_rise && cnt == 6'd7) state_nxt = DATA;
         DATA: if (csl_s) state_nxt = IDLE;
               else if (sclk_rise && cnt == 6'd39) state_nxt = DONE;
         DONE: if (csl_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt     <= '0;
         in_sr   <= '0;
         miso_sr <= '0;
         rw      <= 1'b0;
         rd_pend <= 1'b0;
         we      <= 1'b0;
         re      <= 1'b0;
         addr    <= '0;
         wdat    <= '0;
      end else begin
         we      <= 1'b0;
         re      <= 1'b0;
         rd_pend <= re;
         if (state == IDLE && csl_fall) begin
            cnt     <= '0;
            miso_sr <= '0;
            rw      <= 1'b0;
         end
         if (bit_ok) begin
            in_sr <= {in_sr[30:0], mosi_s};
            if (cnt != 6'd40) cnt <= cnt + 6'd1;
            if (state == HDR && cnt == 6'd7) begin
               addr <= {in_sr[5:0], mosi_s};
               rw   <= in_sr[6];
               re   <= in_sr[6];
            end
            if (state == DATA) begin
               miso_sr <= {miso_sr[30:0], 1'b0};
               if (cnt == 6'd39 && !rw) begin
                  wdat <= {in_sr[30:0], mosi_s};
                  we   <= 1'b1;
               end
            end
         end
         // load lands well inside SCLK high/low windows, so it never meets a shift
         if (rd_pend) miso_sr <= rdat;
      end

   assign miso_bit = (state == DATA) && rw && !csl_s && miso_sr[31];

`ifdef SPI_MISO_TRISTATE_EN
   assign SPI_MISO = (csl_s || !reset_n) ? 1'bz : miso_bit;
`else
   assign SPI_MISO = miso_bit;
`endif

endmodule

// File: tb/tb_spi_regbus_slave.sv
`timescale 1ns/1ps
// Directed bench for spi_regbus_slave: 40 MHz clk, 5 MHz SCLK mode-0 master.
module tb_spi_regbus_slave;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        SPI_CSL = 1'b1;
   logic        SPI_SCLK = 1'b0;
   logic        SPI_MOSI = 1'b0;
   wire         SPI_MISO;
   logic        we, re;
   logic [6:0]  addr;
   logic [31:0] wdat, rdat;

   int          n_chk = 0;
   int          n_fail = 0;
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [6:0]  we_addr = '0;
   logic [6:0]  re_addr = '0;
   logic [31:0] we_dat = '0;
   logic [31:0] we_dat_prev = '0;
   logic [31:0] cap = '0;
   logic        miso_end = 1'b0;

`ifdef SPI_MISO_TRISTATE_EN
   localparam logic MISO_OFF = 1'bz;
`else
   localparam logic MISO_OFF = 1'b0;
`endif

   spi_regbus_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .SPI_CSL(SPI_CSL), .SPI_SCLK(SPI_SCLK),
      .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .we(we), .re(re),
      .addr(addr), .wdat(wdat), .rdat(rdat)
   );

   always #12.5 clk = ~clk;

   // register file contents seen by the slave
   always_comb begin
      case (addr)
         7'h00:   rdat = 32'hDEADBEEF;
         7'h12:   rdat = 32'h12345678;
         default: rdat = 32'hA5A50000;
      endcase
   end

   always @(negedge clk) begin
      if (we) begin
         we_cnt      <= we_cnt + 1;
         we_addr     <= addr;
         we_dat_prev <= we_dat;
         we_dat      <= wdat;
      end
      if (re) begin
         re_cnt  <= re_cnt + 1;
         re_addr <= addr;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish");
      $fatal(1, "watchdog");
   end

   // clocks bits lo..hi of frame (bits past 39 send 1); MISO sampled just before rising edges 9..40
   task automatic spi_bits(input logic [39:0] frame, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         SPI_MOSI = (i < 40) ? frame[39-i] : 1'b1;
         #100;
         if (i >= 8) cap = {cap[30:0], SPI_MISO};
         SPI_SCLK = 1'b1;
         #100;
         SPI_SCLK = 1'b0;
      end
   endtask

   task automatic spi_frame(input logic [39:0] frame, input int nbits, input int csl_hi);
      cap = '0;
      SPI_CSL = 1'b0;
      #200;
      spi_bits(frame, 0, nbits - 1);
      #200;
      miso_end = SPI_MISO;
      SPI_CSL = 1'b1;
      #(csl_hi);
   endtask

   task automatic test_reset;
      #50;
      n_chk += 5;
      if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
      if (re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", re); end
      if (addr !== 7'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", addr); end
      if (wdat !== 32'h0) begin n_fail++; $display("FAIL reset_wdat: got %h want 0", wdat); end
      if (SPI_MISO !== MISO_OFF) begin n_fail++; $display("FAIL reset_miso: got %b want %b", SPI_MISO, MISO_OFF); end
      #50;
      reset_n = 1'b1;
      #300;
      n_chk++;
      if (SPI_MISO !== MISO_OFF) begin n_fail++; $display("FAIL idle_miso: got %b want %b", SPI_MISO, MISO_OFF); end
   endtask

   task automatic test_read;
      int w0, r0;
      w0 = we_cnt; r0 = re_cnt;
      spi_frame({1'b1, 7'h00, 32'h0}, 40, 400);
      n_chk += 5;
      if (re_cnt - r0 !== 1) begin n_fail++; $display("FAIL read_re_count: got %0d want 1", re_cnt - r0); end
      if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL read_we_count: got %0d want 0", we_cnt - w0); end
      if (re_addr !== 7'h00) begin n_fail++; $display("FAIL read_addr: got %h want 00", re_addr); end
      if (cap !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", cap); end
      if (miso_end !== 1'b0) begin n_fail++; $display("FAIL read_miso_after40: got %b want 0", miso_end); end
   endtask

   task automatic test_write;
      int w0, r0;
      w0 = we_cnt; r0 = re_cnt;
      spi_frame({1'b0, 7'h01, 32'd1000}, 40, 400);
      n_chk += 5;
      if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL write_we_count: got %0d want 1", we_cnt - w0); end
      if (re_cnt - r0 !== 0) begin n_fail++; $display("FAIL write_re_count: got %0d want 0", re_cnt - r0); end
      if (we_addr !== 7'h01) begin n_fail++; $display("FAIL write_addr: got %h want 01", we_addr); end
      if (we_dat !== 32'h000003E8) begin n_fail++; $display("FAIL write_wdat: got %h want 000003e8", we_dat); end
      if (cap !== 32'h0) begin n_fail++; $display("FAIL write_miso_quiet: got %h want 0", cap); end
   endtask

   task automatic test_back_to_back;
      int w0;
      w0 = we_cnt;
      // 100 ns = SYNC_STAGES+2 clk of CSL high between frames
      spi_frame({1'b0, 7'h03, 32'd1}, 40, 100);
      spi_frame({1'b0, 7'h03, 32'd0}, 40, 400);
      n_chk += 4;
      if (we_cnt - w0 !== 2) begin n_fail++; $display("FAIL b2b_we_count: got %0d want 2", we_cnt - w0); end
      if (we_dat_prev !== 32'd1) begin n_fail++; $display("FAIL b2b_wdat_first: got %h want 1", we_dat_prev); end
      if (we_dat !== 32'd0) begin n_fail++; $display("FAIL b2b_wdat_second: got %h want 0", we_dat); end
      if (we_addr !== 7'h03) begin n_fail++; $display("FAIL b2b_addr: got %h want 03", we_addr); end
   endtask

   task automatic test_abort;
      int w0, r0;
      w0 = we_cnt; r0 = re_cnt;
      spi_frame({1'b0, 7'h10, 32'hFFFFFFFF}, 20, 400);
      n_chk++;
      if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL abort_no_we: got %0d want 0", we_cnt - w0); end
      spi_frame({1'b0, 7'h11, 32'd0}, 40, 400);
      n_chk += 4;
      if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL abort_we_count: got %0d want 1", we_cnt - w0); end
      if (re_cnt - r0 !== 0) begin n_fail++; $display("FAIL abort_re_count: got %0d want 0", re_cnt - r0); end
      if (we_addr !== 7'h11) begin n_fail++; $display("FAIL abort_addr: got %h want 11", we_addr); end
      if (we_dat !== 32'd0) begin n_fail++; $display("FAIL abort_wdat: got %h want 0", we_dat); end
   endtask

   task automatic test_reset_mid;
      int w0, r0;
      logic [39:0] f;
      f = {1'b1, 7'h12, 32'h0};
      w0 = we_cnt; r0 = re_cnt;
      SPI_CSL = 1'b0;
      #200;
      spi_bits(f, 0, 11);
      // the header completed before reset, so its read strobe is legitimate
      n_chk++;
      if (re_cnt - r0 !== 1) begin n_fail++; $display("FAIL rstmid_pre_re: got %0d want 1", re_cnt - r0); end
      r0 = re_cnt;
      reset_n = 1'b0;
      #50;
      n_chk += 3;
      if (addr !== 7'h00) begin n_fail++; $display("FAIL rstmid_addr: got %h want 00", addr); end
      if (re !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes: got re=%b we=%b want 0", re, we); end
      if (SPI_MISO !== MISO_OFF) begin n_fail++; $display("FAIL rstmid_miso: got %b want %b", SPI_MISO, MISO_OFF); end
      #100;
      reset_n = 1'b1;
      // CSL still low: remaining bits must be ignored
      spi_bits(f, 12, 39);
      #200;
      SPI_CSL = 1'b1;
      #400;
      n_chk += 2;
      if (re_cnt - r0 !== 0) begin n_fail++; $display("FAIL rstmid_post_re: got %0d want 0", re_cnt - r0); end
      if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL rstmid_post_we: got %0d want 0", we_cnt - w0); end
      spi_frame(f, 40, 400);
      n_chk += 3;
      if (re_cnt - r0 !== 1) begin n_fail++; $display("FAIL rstmid_read_re: got %0d want 1", re_cnt - r0); end
      if (re_addr !== 7'h12) begin n_fail++; $display("FAIL rstmid_read_addr: got %h want 12", re_addr); end
      if (cap !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_read_data: got %h want 12345678", cap); end
   endtask

   task automatic test_saturate;
      int w0;
      w0 = we_cnt;
      spi_frame({1'b0, 7'h05, 32'h0F0F0F0F}, 44, 400);
      n_chk += 3;
      if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL sat_we_count: got %0d want 1", we_cnt - w0); end
      if (we_dat !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL sat_wdat: got %h want 0f0f0f0f", we_dat); end
      if (SPI_MISO !== MISO_OFF) begin n_fail++; $display("FAIL sat_idle_miso: got %b want %b", SPI_MISO, MISO_OFF); end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write;
      test_back_to_back;
      test_abort;
      test_reset_mid;
      test_saturate;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
